// File: rtl/adventure_game_engine_if.sv
// Player-facing bus of the adventure game engine: move requests in, game state out.
interface adventure_game_engine_if #(
    parameter int unsigned LW     = 2,
    parameter int unsigned MOVE_W = 8
) ();
    logic              move_valid;
    logic [1:0]        direction;
    logic              restart;
    logic [2:0]        room;
    logic              has_sword;
    logic [LW-1:0]     lives;
    logic [MOVE_W-1:0] moves;
    logic              win;
    logic              dead;
    logic              bump;

    modport master (
        output move_valid, direction, restart,
        input  room, has_sword, lives, moves, win, dead, bump
    );

    modport slave (
        input  move_valid, direction, restart,
        output room, has_sword, lives, moves, win, dead, bump
    );
endinterface

// File: rtl/adventure_game_engine.sv
// Room-map adventure game: move between rooms, grab the sword in the Stash, and
// survive the Dragon's Den encounter, which resolves after a fixed number of ticks.
module adventure_game_engine #(
    parameter int unsigned TICK_DIV  = 3,
    parameter int unsigned DEN_TICKS = 2,
    parameter int unsigned MAX_LIVES = 3,
    parameter int unsigned MOVE_W    = 8
) (
    input logic                    clk,
    input logic                    reset,
    adventure_game_engine_if.slave bus
);
    localparam int unsigned LW = $clog2(MAX_LIVES + 1);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEN_TICKS > 1) ? $clog2(DEN_TICKS) : 1;

    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DenLast   = DW'(DEN_TICKS - 1);
    localparam logic [LW-1:0] LivesInit = LW'(MAX_LIVES);

    localparam logic [1:0] DirN = 2'b00;
    localparam logic [1:0] DirE = 2'b01;
    localparam logic [1:0] DirS = 2'b11;
    localparam logic [1:0] DirW = 2'b10;

    typedef enum logic [2:0] {
        RmCave      = 3'b000,
        RmTunnel    = 3'b001,
        RmRiver     = 3'b010,
        RmStash     = 3'b011,
        RmDen       = 3'b100,
        RmGraveyard = 3'b101,
        RmVault     = 3'b110
    } room_e;

    room_e             room_q, room_d;
    logic              sword_q, sword_d;
    logic [LW-1:0]     lives_q, lives_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic              bump_q, bump_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DW-1:0]     den_q, den_d;

    logic  tick;
    logic  exit_ok;
    room_e exit_room;

    assign tick = (tick_q == TickLast);

    // Exit table: destination for the requested direction from the current room.
    always_comb begin
        exit_ok   = 1'b0;
        exit_room = room_q;
        case (room_q)
            RmCave:   if (bus.direction == DirE) begin exit_ok = 1'b1; exit_room = RmTunnel; end
            RmTunnel: begin
                if (bus.direction == DirW) begin exit_ok = 1'b1; exit_room = RmCave;  end
                if (bus.direction == DirS) begin exit_ok = 1'b1; exit_room = RmRiver; end
            end
            RmRiver: begin
                if (bus.direction == DirN) begin exit_ok = 1'b1; exit_room = RmTunnel; end
                if (bus.direction == DirW) begin exit_ok = 1'b1; exit_room = RmStash;  end
                if (bus.direction == DirE) begin exit_ok = 1'b1; exit_room = RmDen;    end
            end
            RmStash:  if (bus.direction == DirE) begin exit_ok = 1'b1; exit_room = RmRiver; end
            default:  ;
        endcase
    end

    // Next-state: movement, den encounter, terminal-room restart and prescaler.
    always_comb begin
        room_d  = room_q;
        sword_d = sword_q;
        lives_d = lives_q;
        moves_d = moves_q;
        bump_d  = 1'b0;
        den_d   = den_q;
        tick_d  = tick ? '0 : tick_q + 1'b1;

        case (room_q)
            RmCave, RmTunnel, RmRiver, RmStash: begin
                if (bus.move_valid) begin
                    if (exit_ok) begin
                        room_d = exit_room;
                        if (moves_q != '1) moves_d = moves_q + 1'b1;
                        if (exit_room == RmStash) sword_d = 1'b1;
                        if (exit_room == RmDen)   den_d   = '0;
                    end else begin
                        bump_d = 1'b1;
                    end
                end
            end
            RmDen: begin
                bump_d = bus.move_valid;
                if (tick) begin
                    if (den_q == DenLast) begin
                        // Sword is checked only now, at resolution time.
                        if (sword_q) begin
                            room_d = RmVault;
                        end else if (lives_q > LW'(1)) begin
                            lives_d = lives_q - 1'b1;
                            room_d  = RmCave;
                        end else begin
                            lives_d = '0;
                            room_d  = RmGraveyard;
                        end
                    end else begin
                        den_d = den_q + 1'b1;
                    end
                end
            end
            RmVault, RmGraveyard: begin
                if (bus.restart) begin
                    room_d  = RmCave;
                    lives_d = LivesInit;
                    moves_d = '0;
                    sword_d = 1'b0;
                end else begin
                    bump_d = bus.move_valid;
                end
            end
            default: begin
                // Unused encoding recovers to the Cave.
                room_d = RmCave;
                bump_d = bus.move_valid;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            room_q  <= RmCave;
            sword_q <= 1'b0;
            lives_q <= LivesInit;
            moves_q <= '0;
            bump_q  <= 1'b0;
            tick_q  <= '0;
            den_q   <= '0;
        end else begin
            room_q  <= room_d;
            sword_q <= sword_d;
            lives_q <= lives_d;
            moves_q <= moves_d;
            bump_q  <= bump_d;
            tick_q  <= tick_d;
            den_q   <= den_d;
        end
    end

    // Outputs straight from registered state.
    always_comb begin
        bus.room      = room_q;
        bus.has_sword = sword_q;
        bus.lives     = lives_q;
        bus.moves     = moves_q;
        bus.bump      = bump_q;
        bus.win       = (room_q == RmVault);
        bus.dead      = (room_q == RmGraveyard);
    end
endmodule
